// File: rtl/rewind_seq.sv
// Branch-mispredict rewind sequencer: walks the ROB from the tail back to the
// mispredicted branch, returning Tnew registers to the freelist WAY per cycle.
// Optional build macro REWIND_STATS_EN adds saturating rewind statistics.
module rewind_seq #(
  parameter int WAY       = 2,
  parameter int ROB_SIZE  = 32,
  parameter int ROB_IDX_W = 5,
  parameter int PR_W      = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush_valid,
  input  logic [ROB_IDX_W-1:0]      flush_rob_idx,
  input  logic [ROB_IDX_W-1:0]      rob_tail,
  output logic [WAY*ROB_IDX_W-1:0]  rd_idx,
  input  logic [WAY*PR_W-1:0]       rd_T,
  output logic [$clog2(WAY+1)-1:0]  fl_num,
  output logic [WAY*PR_W-1:0]       fl_reg_T,
  output logic                      stall_dispatch,
  output logic                      busy,
  output logic                      rob_tail_set_valid,
  output logic [ROB_IDX_W-1:0]      rob_tail_set,
  output logic                      done
`ifdef REWIND_STATS_EN
  ,
  output logic [15:0]               stat_rewind_count,
  output logic [15:0]               stat_rewind_cycles
`endif
);

  localparam int CNT_W     = $clog2(WAY + 1);
  localparam int WAY_CLAMP = (WAY < ROB_SIZE) ? WAY : ROB_SIZE - 1;
  localparam logic [ROB_IDX_W-1:0] WAY_IDX = ROB_IDX_W'(WAY_CLAMP);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t               state_q, state_d;
  logic [ROB_IDX_W-1:0] cur_q, cur_d;
  logic [ROB_IDX_W-1:0] stop_q, stop_d;
  logic [ROB_IDX_W-1:0] rem_q, rem_d;

  logic                 in_walk;
  logic                 in_done;
  logic [ROB_IDX_W-1:0] n;
  logic [ROB_IDX_W-1:0] cur_adv;
  logic [ROB_IDX_W-1:0] new_stop;
  logic [CNT_W-1:0]     fl_cnt;

  always_comb begin
    in_walk  = !reset && (state_q == WALK);
    in_done  = !reset && (state_q == DONE);
    n        = '0;
    if (in_walk) begin
      n = (rem_q < WAY_IDX) ? rem_q : WAY_IDX;
    end
    cur_adv  = cur_q - n;
    new_stop = flush_rob_idx + ROB_IDX_W'(1);

    state_d = state_q;
    cur_d   = cur_q;
    stop_d  = stop_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (flush_valid) begin
          cur_d   = rob_tail;
          stop_d  = new_stop;
          rem_d   = rob_tail - new_stop;
          state_d = (rem_d != '0) ? WALK : DONE;
        end
      end
      WALK: begin
        cur_d = cur_adv;
        rem_d = rem_q - n;
        // A retarget measures from the position after this cycle's slots.
        if (flush_valid) begin
          stop_d = new_stop;
          rem_d  = cur_adv - new_stop;
        end
        state_d = (rem_d != '0) ? WALK : DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (flush_valid) begin
          stop_d  = new_stop;
          rem_d   = cur_q - new_stop;
          state_d = (rem_d != '0) ? WALK : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      stop_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      stop_q  <= stop_d;
      rem_q   <= rem_d;
    end
  end

  // Slot 0 is the oldest entry of this cycle's group, slot n-1 the youngest.
  genvar gi;
  generate
    for (gi = 0; gi < WAY; gi++) begin : g_slot
      logic slot_used;
      assign slot_used = in_walk && (ROB_IDX_W'(gi) < n);
      assign rd_idx[gi*ROB_IDX_W +: ROB_IDX_W] =
        slot_used ? (cur_adv + ROB_IDX_W'(gi)) : '0;
      assign fl_reg_T[gi*PR_W +: PR_W] =
        slot_used ? rd_T[gi*PR_W +: PR_W] : '0;
    end
  endgenerate

  always_comb begin
    fl_cnt = '0;
    for (int i = 0; i < WAY; i++) begin
      if (fl_reg_T[i*PR_W +: PR_W] != '0) begin
        fl_cnt = fl_cnt + CNT_W'(1);
      end
    end
  end

  assign fl_num             = fl_cnt;
  assign busy               = !reset && (state_q != IDLE);
  assign stall_dispatch     = flush_valid | busy;
  assign rob_tail_set_valid = in_done;
  assign rob_tail_set       = in_done ? stop_q : '0;
  assign done               = in_done;

`ifdef REWIND_STATS_EN
  logic [15:0] stat_count_q, stat_count_d;
  logic [15:0] stat_cycles_q, stat_cycles_d;

  always_comb begin
    stat_count_d  = stat_count_q;
    stat_cycles_d = stat_cycles_q;
    if (in_done && (stat_count_q != 16'hFFFF)) begin
      stat_count_d = stat_count_q + 16'd1;
    end
    if (in_walk && (stat_cycles_q != 16'hFFFF)) begin
      stat_cycles_d = stat_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_count_q  <= '0;
      stat_cycles_q <= '0;
    end else begin
      stat_count_q  <= stat_count_d;
      stat_cycles_q <= stat_cycles_d;
    end
  end

  assign stat_rewind_count  = stat_count_q;
  assign stat_rewind_cycles = stat_cycles_q;
`endif

endmodule

// File: tb/tb_rewind_seq.sv
// Directed bench for rewind_seq (WAY=2, ROB_SIZE=32): a vector table for the
// basic walks plus hand-written retarget, reset-abort and maximum-walk runs.
module tb_rewind_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_valid;
  logic [4:0]  flush_rob_idx;
  logic [4:0]  rob_tail;
  logic [9:0]  rd_idx;
  logic [11:0] rd_T;
  logic [1:0]  fl_num;
  logic [11:0] fl_reg_T;
  logic        stall_dispatch;
  logic        busy;
  logic        rob_tail_set_valid;
  logic [4:0]  rob_tail_set;
  logic        done;
`ifdef REWIND_STATS_EN
  logic [15:0] stat_rewind_count;
  logic [15:0] stat_rewind_cycles;
`endif

  int checks = 0;
  int errors = 0;

  rewind_seq #(.WAY(2), .ROB_SIZE(32), .ROB_IDX_W(5), .PR_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .flush_valid(flush_valid),
    .flush_rob_idx(flush_rob_idx),
    .rob_tail(rob_tail),
    .rd_idx(rd_idx),
    .rd_T(rd_T),
    .fl_num(fl_num),
    .fl_reg_T(fl_reg_T),
    .stall_dispatch(stall_dispatch),
    .busy(busy),
    .rob_tail_set_valid(rob_tail_set_valid),
    .rob_tail_set(rob_tail_set),
    .done(done)
`ifdef REWIND_STATS_EN
    ,
    .stat_rewind_count(stat_rewind_count),
    .stat_rewind_cycles(stat_rewind_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [4:0]  fidx;
    logic [4:0]  tail;
    logic [11:0] rdt;
    logic [9:0]  e_idx;
    logic [1:0]  e_num;
    logic [11:0] e_fl;
    logic        e_stall;
    logic        e_busy;
    logic        e_tsv;
    logic [4:0]  e_tset;
    logic        e_done;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [9:0] pi(input int s0, input int s1);
    return {5'(s1), 5'(s0)};
  endfunction

  function automatic logic [11:0] pt(input int s0, input int s1);
    return {6'(s1), 6'(s0)};
  endfunction

  function automatic vec_t mk(input logic rst, input logic fv, input int fidx,
                              input int tail, input logic [11:0] rdt,
                              input logic [9:0] e_idx, input int e_num,
                              input logic [11:0] e_fl, input logic e_stall,
                              input logic e_busy, input logic e_tsv,
                              input int e_tset, input logic e_done);
    vec_t v;
    v.rst = rst; v.fv = fv; v.fidx = 5'(fidx); v.tail = 5'(tail); v.rdt = rdt;
    v.e_idx = e_idx; v.e_num = 2'(e_num); v.e_fl = e_fl; v.e_stall = e_stall;
    v.e_busy = e_busy; v.e_tsv = e_tsv; v.e_tset = 5'(e_tset); v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d, want %0d", nm, step, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fv, input int fidx,
                       input int tail, input logic [11:0] rdt);
    @(negedge clock);
    reset         = rst;
    flush_valid   = fv;
    flush_rob_idx = 5'(fidx);
    rob_tail      = 5'(tail);
    rd_T          = rdt;
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk("rd_idx", i, 32'(rd_idx), 32'(v.e_idx));
    chk("fl_num", i, 32'(fl_num), 32'(v.e_num));
    chk("fl_reg_T", i, 32'(fl_reg_T), 32'(v.e_fl));
    chk("stall_dispatch", i, 32'(stall_dispatch), 32'(v.e_stall));
    chk("busy", i, 32'(busy), 32'(v.e_busy));
    chk("rob_tail_set_valid", i, 32'(rob_tail_set_valid), 32'(v.e_tsv));
    chk("rob_tail_set", i, 32'(rob_tail_set), 32'(v.e_tset));
    chk("done", i, 32'(done), 32'(v.e_done));
  endtask

  initial begin
    int walk_cycles;
    int done_pulses;
    logic [9:0] last_idx;

    reset = 1'b1; flush_valid = 1'b0; flush_rob_idx = '0; rob_tail = '0; rd_T = '0;

    // Reset with a flush pending, then the basic walks.
    vecs[0]  = mk(1, 1, 3, 8, 12'd0, 10'd0, 0, 12'd0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 12'd0, 10'd0, 0, 12'd0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 12'd0, 10'd0, 0, 12'd0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 3, 8, 12'd0, 10'd0, 0, 12'd0, 1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, pt(40, 41), pi(6, 7), 2, pt(40, 41), 1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, pt(42, 43), pi(4, 5), 2, pt(42, 43), 1, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, pt(9, 9), 10'd0, 0, 12'd0, 1, 1, 1, 4, 1);
    vecs[7]  = mk(0, 0, 0, 0, pt(9, 9), 10'd0, 0, 12'd0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 30, 2, 12'd0, 10'd0, 0, 12'd0, 1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, pt(11, 12), pi(0, 1), 2, pt(11, 12), 1, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, pt(13, 14), pi(31, 0), 1, pt(13, 0), 1, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 12'd0, 10'd0, 0, 12'd0, 1, 1, 1, 31, 1);
    vecs[12] = mk(0, 0, 0, 0, 12'd0, 10'd0, 0, 12'd0, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 7, 8, 12'd0, 10'd0, 0, 12'd0, 1, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, pt(5, 5), 10'd0, 0, 12'd0, 1, 1, 1, 8, 1);
    vecs[15] = mk(0, 0, 0, 0, 12'd0, 10'd0, 0, 12'd0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 20, 24, 12'd0, 10'd0, 0, 12'd0, 1, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, pt(0, 17), pi(22, 23), 1, pt(0, 17), 1, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, pt(0, 0), pi(21, 0), 0, 12'd0, 1, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 12'd0, 10'd0, 0, 12'd0, 1, 1, 1, 21, 1);
    vecs[20] = mk(0, 0, 0, 0, 12'd0, 10'd0, 0, 12'd0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].fv, int'(vecs[i].fidx), int'(vecs[i].tail), vecs[i].rdt);
      check_vec(i, vecs[i]);
      $display("vec %0d: rd_idx=%h fl_num=%0d fl_reg_T=%h busy=%b done=%b tset=%0d",
               i, rd_idx, fl_num, fl_reg_T, busy, done, rob_tail_set);
    end

    // Reset in the middle of a walk aborts it without a done pulse.
    drive(0, 1, 0, 10, 12'd0);
    drive(0, 0, 0, 0, pt(1, 2));
    chk("abort_first_slots", 100, 32'(rd_idx), 32'(pi(8, 9)));
    drive(1, 0, 0, 0, pt(1, 2));
    chk("abort_busy_in_reset", 101, 32'(busy), 32'd0);
    chk("abort_rd_idx_in_reset", 101, 32'(rd_idx), 32'd0);
    chk("abort_fl_num_in_reset", 101, 32'(fl_num), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, pt(1, 2));
      chk("abort_no_done", 102 + k, 32'(done), 32'd0);
      chk("abort_idle", 102 + k, 32'(busy), 32'd0);
    end
    $display("reset-abort sequence complete");

    // Retarget during the first walk cycle: 10 -> 5, walk ends at entry 6.
    done_pulses = 0;
    drive(0, 1, 10, 20, 12'd0);
    chk("retarget_stall", 110, 32'(stall_dispatch), 32'd1);
    drive(0, 1, 5, 20, pt(3, 4));
    chk("retarget_first_slots", 111, 32'(rd_idx), 32'(pi(18, 19)));
    chk("retarget_first_fl", 111, 32'(fl_reg_T), 32'(pt(3, 4)));
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, pt(7, 8));
      chk("retarget_walk_slots", 112 + k, 32'(rd_idx), 32'(pi(16 - 2 * k, 17 - 2 * k)));
      chk("retarget_walk_busy", 112 + k, 32'(busy), 32'd1);
      if (done) done_pulses++;
    end
    drive(0, 0, 0, 0, 12'd0);
    chk("retarget_done", 118, 32'(done), 32'd1);
    chk("retarget_tail_set", 118, 32'(rob_tail_set), 32'd6);
    if (done) done_pulses++;
    drive(0, 0, 0, 0, 12'd0);
    if (done) done_pulses++;
    chk("retarget_single_done", 119, 32'(done_pulses), 32'd1);
    chk("retarget_back_idle", 119, 32'(busy), 32'd0);
`ifdef REWIND_STATS_EN
    chk("stat_rewind_count", 119, 32'(stat_rewind_count), 32'd1);
    chk("stat_rewind_cycles", 119, 32'(stat_rewind_cycles), 32'd7);
`endif
    $display("retarget sequence complete: done pulses=%0d", done_pulses);

    // Largest walk: branch 5, tail 5 -> 31 entries, 16 walk cycles.
    walk_cycles = 0;
    done_pulses = 0;
    last_idx = '0;
    drive(0, 1, 5, 5, 12'd0);
    for (int k = 0; k < 40; k++) begin
      drive(0, 0, 0, 0, pt(1, 1));
      if (k == 0) chk("maxrem_first_slots", 120, 32'(rd_idx), 32'(pi(3, 4)));
      if (done) begin
        done_pulses++;
        chk("maxrem_tail_set", 121, 32'(rob_tail_set), 32'd6);
        break;
      end
      if (busy) begin
        walk_cycles++;
        last_idx = rd_idx;
      end
    end
    chk("maxrem_done_seen", 122, 32'(done_pulses), 32'd1);
    chk("maxrem_walk_cycles", 122, 32'(walk_cycles), 32'd16);
    chk("maxrem_last_slots", 122, 32'(last_idx), 32'(pi(6, 0)));
    $display("max-walk sequence complete: walk cycles=%0d", walk_cycles);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
